// File: rtl/kp_pkg.sv
// kp_pkg: shared state type, row/column constants and column rotation for the keypad scanner.
package kp_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kpscan_state_t;
    localparam logic [3:0] KP_IDLE = 4'b1111;
    localparam logic [3:0] KP_COL_INIT = 4'b0111;
    // Active-low one-hot step: 0111 -> 1011 -> 1101 -> 1110 -> 0111
    function automatic logic [3:0] rot_col(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction
endpackage

// File: rtl/kpscan_if.sv
// kpscan_if: keypad matrix pins plus the debounced key outputs shared with the decoder.
interface kpscan_if;
    logic [3:0] kpr_in;
    logic [3:0] kpc;
    logic [3:0] kpr;
    logic       key_valid;
    logic       key_press;
    modport master (input kpr_in, output kpc, kpr, key_valid, key_press);
    modport slave  (output kpr_in, input kpc, kpr, key_valid, key_press);
endinterface

// File: rtl/kpsync.sv
// kpsync: W-bit two-flop synchronizer with asynchronous active-low reset to RST_VAL.
module kpsync #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/kpscan.sv
// kpscan: rotating column scanner with row synchronizer and press/release debouncer.
module kpscan
    import kp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic      clk,
    input  logic      reset_n,
    kpscan_if.master  bus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    kpscan_state_t state, state_n;
    logic [DW-1:0] div;
    logic          tick, idle;
    logic [3:0]    kpr, kpc, kpc_n, cap, cap_n;
    logic [CW-1:0] db_cnt, db_cnt_n, db_inc;
    logic          valid, valid_n, press, press_n;

    kpsync #(.W(4), .RST_VAL(KP_IDLE)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.kpr_in),
        .q       (kpr)
    );

    assign tick          = (div == DIV_MAX);
    assign idle          = (kpr == KP_IDLE);
    assign db_inc        = db_cnt + CNT_ONE;
    assign bus.kpr       = kpr;
    assign bus.kpc       = kpc;
    assign bus.key_valid = valid;
    assign bus.key_press = press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            state  <= SCAN;
            kpc    <= KP_COL_INIT;
            cap    <= KP_IDLE;
            db_cnt <= '0;
            valid  <= 1'b0;
            press  <= 1'b0;
        end else begin
            div    <= tick ? '0 : div + DW'(1);
            state  <= state_n;
            kpc    <= kpc_n;
            cap    <= cap_n;
            db_cnt <= db_cnt_n;
            valid  <= valid_n;
            press  <= press_n;
        end
    end

    // Every decision waits for tick so the frozen column has a full scan period to settle.
    always_comb begin
        state_n  = state;
        kpc_n    = kpc;
        cap_n    = cap;
        db_cnt_n = db_cnt;
        valid_n  = valid;
        press_n  = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (idle) begin
                        kpc_n = rot_col(kpc);
                    end else begin
                        cap_n    = kpr;
                        db_cnt_n = CNT_ONE;
                        state_n  = (DEBOUNCE_CNT == 1) ? HELD : DEBOUNCE;
                        valid_n  = (DEBOUNCE_CNT == 1);
                        press_n  = (DEBOUNCE_CNT == 1);
                    end
                end
                DEBOUNCE: begin
                    if (kpr == cap) begin
                        db_cnt_n = db_inc;
                        if (db_inc == DB_MAX) begin
                            state_n = HELD;
                            valid_n = 1'b1;
                            press_n = 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    if (idle) begin
                        db_cnt_n = CNT_ONE;
                        state_n  = (DEBOUNCE_CNT == 1) ? SCAN : RELEASE;
                        valid_n  = (DEBOUNCE_CNT != 1);
                    end
                end
                RELEASE: begin
                    if (idle) begin
                        db_cnt_n = db_inc;
                        if (db_inc == DB_MAX) begin
                            state_n = SCAN;
                            valid_n = 1'b0;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_kpscan.sv
// tb_kpscan: directed tick-by-tick vectors against a one-key keypad model (key "5").
module tb_kpscan;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key = 1'b0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b1111;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         press_seen = 0;

    kpscan_if kif();

    kpscan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (kif.master)
    );

    always #5 clk = ~clk;

    // Key "5" pulls row 1 low only while column 1 is driven low.
    assign kif.kpr_in = force_en ? force_val : ((key && kif.kpc == 4'b1011) ? 4'b1011 : 4'b1111);

    always @(negedge clk) if (kif.key_press === 1'b1) press_seen++;

    typedef struct {
        logic       key;
        logic [3:0] kpr_pre;
        logic [3:0] kpc;
        logic       valid;
        logic       press;
    } vec_t;

    vec_t tbl[39];

    function automatic vec_t mk(input logic k, input logic [3:0] r, input logic [3:0] c, input logic v, input logic p);
        vec_t t;
        t.key = k; t.kpr_pre = r; t.kpc = c; t.valid = v; t.press = p;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Starts and ends on a negedge; returns kpr as seen just before the tick edge.
    task automatic do_tick(output logic [3:0] kpr_pre);
        repeat (3) @(posedge clk);
        @(negedge clk);
        kpr_pre = kif.kpr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] pre;
        localparam logic [3:0] F = 4'b1111, B = 4'b1011;
        tbl[0]  = mk(0, F, 4'b1011, 0, 0);
        tbl[1]  = mk(0, F, 4'b1101, 0, 0);
        tbl[2]  = mk(0, F, 4'b1110, 0, 0);
        tbl[3]  = mk(0, F, 4'b0111, 0, 0);
        tbl[4]  = mk(0, F, 4'b1011, 0, 0);
        tbl[5]  = mk(1, B, 4'b1011, 0, 0);
        tbl[6]  = mk(1, B, 4'b1011, 0, 0);
        tbl[7]  = mk(1, B, 4'b1011, 1, 1);
        tbl[8]  = mk(1, B, 4'b1011, 1, 0);
        tbl[9]  = mk(1, B, 4'b1011, 1, 0);
        tbl[10] = mk(0, F, 4'b1011, 1, 0);
        tbl[11] = mk(0, F, 4'b1011, 1, 0);
        tbl[12] = mk(0, F, 4'b1011, 0, 0);
        tbl[13] = mk(0, F, 4'b1101, 0, 0);
        tbl[14] = mk(0, F, 4'b1110, 0, 0);
        tbl[15] = mk(0, F, 4'b0111, 0, 0);
        tbl[16] = mk(0, F, 4'b1011, 0, 0);
        tbl[17] = mk(1, B, 4'b1011, 0, 0);
        tbl[18] = mk(0, F, 4'b1011, 0, 0);
        tbl[19] = mk(0, F, 4'b1101, 0, 0);
        tbl[20] = mk(0, F, 4'b1110, 0, 0);
        tbl[21] = mk(0, F, 4'b0111, 0, 0);
        tbl[22] = mk(0, F, 4'b1011, 0, 0);
        tbl[23] = mk(1, B, 4'b1011, 0, 0);
        tbl[24] = mk(1, B, 4'b1011, 0, 0);
        tbl[25] = mk(1, B, 4'b1011, 1, 1);
        tbl[26] = mk(0, F, 4'b1011, 1, 0);
        tbl[27] = mk(1, B, 4'b1011, 1, 0);
        tbl[28] = mk(1, B, 4'b1011, 1, 0);
        tbl[29] = mk(0, F, 4'b1011, 1, 0);
        tbl[30] = mk(0, F, 4'b1011, 1, 0);
        tbl[31] = mk(0, F, 4'b1011, 0, 0);
        tbl[32] = mk(0, F, 4'b1101, 0, 0);
        tbl[33] = mk(0, F, 4'b1110, 0, 0);
        tbl[34] = mk(0, F, 4'b0111, 0, 0);
        tbl[35] = mk(0, F, 4'b1011, 0, 0);
        tbl[36] = mk(1, B, 4'b1011, 0, 0);
        tbl[37] = mk(1, B, 4'b1011, 0, 0);
        tbl[38] = mk(1, B, 4'b1011, 1, 1);

        repeat (2) @(negedge clk);
        chk("rst_kpc", kif.kpc, 4'b0111);
        chk("rst_kpr", kif.kpr, 4'b1111);
        chk("rst_valid", {3'b0, kif.key_valid}, 4'b0000);
        chk("rst_press", {3'b0, kif.key_press}, 4'b0000);

        // Synchronizer latency: a row change shows on kpr after exactly two edges.
        reset_n = 1'b1;
        force_en = 1'b1;
        force_val = 4'b1110;
        @(negedge clk);
        chk("sync_lag1", kif.kpr, 4'b1111);
        @(negedge clk);
        chk("sync_lag2", kif.kpr, 4'b1110);
        reset_n = 1'b0;
        force_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 39; i++) begin
            key = tbl[i].key;
            do_tick(pre);
            chk($sformatf("v%0d_kpr", i), pre, tbl[i].kpr_pre);
            chk($sformatf("v%0d_kpc", i), kif.kpc, tbl[i].kpc);
            chk($sformatf("v%0d_valid", i), {3'b0, kif.key_valid}, {3'b0, tbl[i].valid});
            chk($sformatf("v%0d_press", i), {3'b0, kif.key_press}, {3'b0, tbl[i].press});
        end

        // Asynchronous reset while held, away from any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_kpc", kif.kpc, 4'b0111);
        chk("arst_kpr", kif.kpr, 4'b1111);
        chk("arst_valid", {3'b0, kif.key_valid}, 4'b0000);
        chk("arst_press", {3'b0, kif.key_press}, 4'b0000);
        key = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_tick(pre);
        chk("restart_kpc1", kif.kpc, 4'b1011);
        do_tick(pre);
        chk("restart_kpc2", kif.kpc, 4'b1101);
        chk("restart_valid", {3'b0, kif.key_valid}, 4'b0000);

        chk("press_pulses", 4'(press_seen), 4'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
